// File: rtl/ctrl_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the instruction field layout, the opcode and state encodings,
// and the opcode-to-class mapping used by the decoder.
package ctrl_pkg;

    // Data / instruction width and register-file geometry
    localparam int W      = 10;
    localparam int NREG   = 4;
    localparam int RW     = $clog2(NREG);

    // Instruction field bit positions
    localparam int OP_HI  = 9;
    localparam int OP_LO  = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 4;
    localparam int RY_HI  = 3;
    localparam int RY_LO  = 2;
    localparam int RSV_HI = 1;
    localparam int RSV_LO = 0;

    // Opcode field values; the upper six encodings are illegal and run as NOP
    typedef enum logic [3:0] {
        OP_LD    = 4'b0000,
        OP_MOV   = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_INV   = 4'b0100,
        OP_AND   = 4'b0101,
        OP_OR    = 4'b0110,
        OP_XOR   = 4'b0111,
        OP_SHL   = 4'b1000,
        OP_SHR   = 4'b1001,
        OP_ILL_A = 4'b1010,
        OP_ILL_B = 4'b1011,
        OP_ILL_C = 4'b1100,
        OP_ILL_D = 4'b1101,
        OP_ILL_E = 4'b1110,
        OP_ILL_F = 4'b1111
    } opcode_t;

    // Sequencer states; T0..T3 are the instruction timesteps
    typedef enum logic [2:0] {
        S_RST = 3'd0,
        T0    = 3'd1,
        T1    = 3'd2,
        T2    = 3'd3,
        T3    = 3'd4
    } state_t;

    // Execution class of an instruction, which selects the T1..T3 behaviour
    typedef enum logic [1:0] {
        CLS_LD  = 2'd0,
        CLS_MOV = 2'd1,
        CLS_ALU = 2'd2,
        CLS_NOP = 2'd3
    } op_class_t;

    // Map an opcode to its execution class; anything unrecognised is a NOP
    function automatic op_class_t op_class_of(input opcode_t op);
        op_class_t cls;
        case (op)
            OP_LD:   cls = CLS_LD;
            OP_MOV:  cls = CLS_MOV;
            OP_ADD,
            OP_SUB,
            OP_INV,
            OP_AND,
            OP_OR,
            OP_XOR,
            OP_SHL,
            OP_SHR:  cls = CLS_ALU;
            default: cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_unit_fsm_if.sv
// Control bundle between the sequencer and the datapath.
// The sequencer (master) receives IR and drives every control line;
// the datapath (slave) supplies IR and consumes the controls.
interface control_unit_fsm_if;
    import ctrl_pkg::*;

    logic [W-1:0]  IR;
    logic          Ext;
    logic          IRin;
    logic [RW-1:0] Rin;
    logic [RW-1:0] Rout;
    logic          ENW;
    logic          ENR;
    logic          Ain;
    logic          Gin;
    logic          Gout;
    logic [3:0]    ALUcont;
    logic          Clr;
    logic [1:0]    TIME;
    logic          Done;

    modport master (
        input  IR,
        output Ext, IRin, Rin, Rout, ENW, ENR, Ain, Gin, Gout,
        output ALUcont, Clr, TIME, Done
    );

    modport slave (
        output IR,
        input  Ext, IRin, Rin, Rout, ENW, ENR, Ain, Gin, Gout,
        input  ALUcont, Clr, TIME, Done
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits IR into its execution class,
// register indices and ALU function select. The two reserved low bits
// are accepted but play no part in execution.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [W-1:0]  ir,
    output op_class_t     op_class,
    output logic [RW-1:0] rx,
    output logic [RW-1:0] ry,
    output logic [3:0]    alu_cont
);

    opcode_t op_s;
    logic    reserved_unused_s;

    assign op_s              = opcode_t'(ir[OP_HI:OP_LO]);
    assign rx                = ir[RX_HI:RX_LO];
    assign ry                = ir[RY_HI:RY_LO];
    assign reserved_unused_s = ^ir[RSV_HI:RSV_LO];

    // Classify the opcode and pass its raw value on as the ALU function
    always_comb begin
        op_class = op_class_of(op_s);
        alu_cont = ir[OP_HI:OP_LO];
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Instruction sequencer. Steps each instruction through T0..T3 on the
// rising edge of the debounced step clock and drives the datapath
// controls as a pure Moore decode of (state, IR). The state register is
// the only storage; IR itself lives in the datapath.
module control_unit_fsm
    import ctrl_pkg::*;
(
    input  logic               CLKb,
    input  logic               RSTb,
    control_unit_fsm_if.master bus
);

    state_t        state_r;

    op_class_t     op_class_s;
    logic [RW-1:0] rx_s;
    logic [RW-1:0] ry_s;
    logic [3:0]    alu_cont_s;

    logic          ext_s;
    logic          irin_s;
    logic [RW-1:0] rin_s;
    logic [RW-1:0] rout_s;
    logic          enw_s;
    logic          enr_s;
    logic          ain_s;
    logic          gin_s;
    logic          gout_s;
    logic [3:0]    alucont_s;
    logic          clr_s;
    logic [1:0]    time_s;
    logic          done_s;

    instr_decode u_instr_decode (
        .ir       (bus.IR),
        .op_class (op_class_s),
        .rx       (rx_s),
        .ry       (ry_s),
        .alu_cont (alu_cont_s)
    );

    // State register: synchronous reset from any state, otherwise advance one timestep
    always_ff @(posedge CLKb) begin
        if (!RSTb) begin
            state_r <= S_RST;
        end else begin
            case (state_r)
                S_RST: state_r <= T0;
                T0:    state_r <= T1;
                T1: begin
                    if (op_class_s == CLS_ALU) begin
                        state_r <= T2;
                    end else begin
                        state_r <= T0;
                    end
                end
                T2:      state_r <= T3;
                T3:      state_r <= T0;
                default: state_r <= S_RST;
            endcase
        end
    end

    // Per-state control decode; every control not named for a state stays 0,
    // so at most one BUS driver is ever active and ALUcont is 0 outside T2
    always_comb begin
        ext_s     = 1'b0;
        irin_s    = 1'b0;
        rin_s     = {RW{1'b0}};
        rout_s    = {RW{1'b0}};
        enw_s     = 1'b0;
        enr_s     = 1'b0;
        ain_s     = 1'b0;
        gin_s     = 1'b0;
        gout_s    = 1'b0;
        alucont_s = 4'b0000;
        clr_s     = 1'b0;
        time_s    = 2'd0;
        done_s    = 1'b0;
        case (state_r)
            S_RST: begin
                clr_s = 1'b1;
            end
            T0: begin
                time_s = 2'd0;
                ext_s  = 1'b1;
                irin_s = 1'b1;
            end
            T1: begin
                time_s = 2'd1;
                case (op_class_s)
                    CLS_LD: begin
                        ext_s  = 1'b1;
                        enw_s  = 1'b1;
                        rin_s  = rx_s;
                        done_s = 1'b1;
                    end
                    CLS_MOV: begin
                        enr_s  = 1'b1;
                        rout_s = ry_s;
                        enw_s  = 1'b1;
                        rin_s  = rx_s;
                        done_s = 1'b1;
                    end
                    CLS_ALU: begin
                        enr_s  = 1'b1;
                        rout_s = rx_s;
                        ain_s  = 1'b1;
                    end
                    CLS_NOP: begin
                        done_s = 1'b1;
                    end
                    default: begin
                        done_s = 1'b1;
                    end
                endcase
            end
            T2: begin
                time_s    = 2'd2;
                enr_s     = 1'b1;
                rout_s    = ry_s;
                gin_s     = 1'b1;
                alucont_s = alu_cont_s;
            end
            T3: begin
                time_s = 2'd3;
                gout_s = 1'b1;
                enw_s  = 1'b1;
                rin_s  = rx_s;
                done_s = 1'b1;
            end
            default: begin
                clr_s = 1'b1;
            end
        endcase
    end

    assign bus.Ext     = ext_s;
    assign bus.IRin    = irin_s;
    assign bus.Rin     = rin_s;
    assign bus.Rout    = rout_s;
    assign bus.ENW     = enw_s;
    assign bus.ENR     = enr_s;
    assign bus.Ain     = ain_s;
    assign bus.Gin     = gin_s;
    assign bus.Gout    = gout_s;
    assign bus.ALUcont = alucont_s;
    assign bus.Clr     = clr_s;
    assign bus.TIME    = time_s;
    assign bus.Done    = done_s;

endmodule
